param_seq_multiplier: RTL and testbench
=======================================

# param_seq_multiplier

Parametrised radix-2 shift-add sequential multiplier. It is the successor to the fixed 5-bit sequential multiplier and is used by the MAC datapath. It adds an operand width parameter, a per-operation signed/unsigned mode, and valid/ready handshakes on both the input and result sides. A result is held until the consumer accepts it.

## Interface

**Parameters**
- WIDTH, default 5: operand width in bits; legal range 2..32.

**Ports**
- mul_clk_i, input, 1: sole clock, rising edge.
- mul_reset_i, input, 1: reset, asynchronous, active-high.
- in_valid_i, input, 1: operands and mode are valid.
- in_ready_o, output, 1: block can accept operands (the fetching-input indicator).
- multiplicand_i, input, WIDTH: operand A.
- multiplier_i, input, WIDTH: operand B.
- signed_i, input, 1: 1 = two's-complement operands, 0 = unsigned. Sampled with the operands.
- out_valid_o, output, 1: mul_result_o is valid (the is-result indicator).
- out_ready_i, input, 1: consumer accepts the result.
- mul_result_o, output, 2*WIDTH: product.

## Operation

**States:** IDLE, CALC, DONE. Reset state is IDLE.

**IDLE**
- in_ready_o = 1.
- On in_valid_i & in_ready_o, the block captures:
  - |A| into a 2*WIDTH shift register.
  - |B| into a WIDTH shift register.
  - The result sign: signed_i & (A[W-1] ^ B[W-1]).
- The accumulator is cleared, the bit counter is cleared, and the state goes to CALC.

**CALC**
- Each cycle:
  - If B_reg[0] = 1, the accumulator adds A_reg.
  - A_reg shifts left 1; B_reg shifts right 1; the counter increments.
- After the WIDTH-th CALC cycle:
  - mul_result_o is loaded with the accumulator, negated if the sign flag is set.
  - The state goes to DONE.

**DONE**
- out_valid_o = 1 and mul_result_o is held stable.
- On out_ready_i the state goes to IDLE.
- in_ready_o = 0 in CALC and DONE; a new operation is never accepted in the same cycle as result acceptance.

**Arithmetic rules**
- Magnitude of -2^(W-1) is 2^(W-1), which fits in WIDTH bits unsigned.
- Product magnitude is at most 2^(2W-2), so the negated result always fits in 2*WIDTH bits.
- A zero product is never reported as negative.
- Unsigned mode ignores operand MSB sign semantics.

**Reset**
- Asserting mul_reset_i at any time, including mid-CALC or in DONE, immediately forces IDLE.
- The operation in progress is discarded; it is never completed or reported.

## Timing

- Reset values:
  - out_valid_o = 0.
  - mul_result_o = 0.
  - in_ready_o = 0 while mul_reset_i is high; it goes to 1 in the first cycle after deassertion.
- Latency: operands are accepted at edge N; out_valid_o rises after edge N+WIDTH (macro off).
- Throughput, macro off, with out_ready_i held high: one result per WIDTH+2 cycles.
- mul_result_o keeps its last value after acceptance until the next result is loaded.
- Inputs are ignored outside the IDLE handshake cycle. Operand changes during CALC have no effect.
- out_ready_i is ignored when out_valid_o = 0.

## Configuration

- Macro MUL_EARLY_TERM_EN.
- **Defined:** CALC also exits to DONE after any cycle in which the post-shift B_reg == 0.
  - Latency = max(1, position of highest set bit of |B| + 1).
  - Example: |B| = 0 gives 1 cycle; |B| = 1 gives 1 cycle; |B| = 0b00100 gives 3 cycles.
  - Results are identical to the non-early-terminating path.
- **Undefined:** CALC always runs exactly WIDTH cycles, giving fixed latency.

## Structure

- **Shared package mul_pkg:**
  - State encoding constants IDLE/CALC/DONE (2-bit).
  - Legal WIDTH bounds.
- **Sub-module mul_cond_negate:**
  - Combinational conditional two's complement, parametrised by width.
  - Instantiated three times:
    - operand A magnitude;
    - operand B magnitude;
    - final result sign fix.
- All other logic (FSM, counter, shift registers, accumulator) is in the top module.

## Test plan

1. WIDTH=5, unsigned, A=31, B=31, out_ready_i=1 → out_valid_o rises 5 cycles after accept; result = 961 (10'h3C1).
2. WIDTH=5, signed, A=5'b10101 (-11), B=5'b01010 (10) → result = -110 (10'h392). Same operands unsigned (21×10) → 210.
3. WIDTH=8, signed, A=-128, B=-128 → 16384; A=-128, B=127 → -16256; A=0, B=-5 → 0 with no negative zero.
4. Backpressure: out_ready_i=0 for 10 cycles after result → out_valid_o and mul_result_o stay stable, in_ready_o stays 0. Raising out_ready_i gives IDLE next cycle, then a new accept.
5. Reset mid-CALC (cycle 2 of 5) → out_valid_o=0, mul_result_o=0, in_ready_o=0 during reset. After release the next operation (3×4) → 12 with normal latency.
6. With MUL_EARLY_TERM_EN: B=0 gives a result after 1 cycle; B=1 after 1; B=4 after 3; B=-16 (WIDTH=5, signed) after 5. All products are correct (A=7 gives 0, 7, 28, -112).

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier family.
//   - FSM state encoding (2-bit): IDLE, CALC, DONE
//   - legal operand width bounds
package mul_pkg;

   localparam int MUL_WIDTH_MIN = 2;
   localparam int MUL_WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mul_cond_negate.sv
// Combinational conditional two's complement.
// Ports:
//   data_i  [W-1:0]  value to pass through or negate
//   neg_i            1 = output the two's complement of data_i
//   data_o  [W-1:0]  result
// Negating the most negative value returns the same bit pattern, which read
// as unsigned is exactly its magnitude.
module mul_cond_negate
   import mul_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [W-1:0] data_i,
   input  logic         neg_i,
   output logic [W-1:0] data_o
);

   assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/param_seq_multiplier.sv
// Parametrised radix-2 shift-add sequential multiplier with valid/ready
// handshakes on operands and result, and per-operation signed/unsigned mode.
// Operands are converted to magnitudes on accept; the sign is re-applied
// to the accumulated product when it is loaded into the result register.
//
// Build option: MUL_EARLY_TERM_EN - when defined, CALC also ends as soon as
// the remaining multiplier bits are all zero (data-dependent latency).
//
// Ports:
//   mul_clk_i                 clock, rising edge
//   mul_reset_i               asynchronous active-high reset
//   in_valid_i / in_ready_o   operand handshake
//   multiplicand_i [W-1:0]    operand A
//   multiplier_i   [W-1:0]    operand B
//   signed_i                  1 = two's-complement operands
//   out_valid_o / out_ready_i result handshake
//   mul_result_o   [2W-1:0]   product, held until the next result loads
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for operands; accept loads magnitudes and sign
// CALC  | one shift-add step per cycle
// DONE  | result valid, waiting for the consumer
module param_seq_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic                 mul_clk_i,
   input  logic                 mul_reset_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     multiplicand_i,
   input  logic [WIDTH-1:0]     multiplier_i,
   input  logic                 signed_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [2*WIDTH-1:0]   mul_result_o
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   if (WIDTH < MUL_WIDTH_MIN || WIDTH > MUL_WIDTH_MAX) begin : g_bad_width
      $error("param_seq_multiplier: WIDTH out of range");
   end

   mul_state_e        state_q, state_d;
   logic [PW-1:0]     a_q, a_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     res_q, res_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sign_q, sign_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [PW-1:0]     acc_sum, res_fix;
   logic [WIDTH-1:0]  b_shift;
   logic              last_cycle;

   mul_cond_negate #(.W(WIDTH)) u_neg_a (
      .data_i (multiplicand_i),
      .neg_i  (signed_i & multiplicand_i[WIDTH-1]),
      .data_o (a_mag)
   );

   mul_cond_negate #(.W(WIDTH)) u_neg_b (
      .data_i (multiplier_i),
      .neg_i  (signed_i & multiplier_i[WIDTH-1]),
      .data_o (b_mag)
   );

   // A zero product negates to zero, so no negative zero can appear.
   mul_cond_negate #(.W(PW)) u_neg_res (
      .data_i (acc_sum),
      .neg_i  (sign_q),
      .data_o (res_fix)
   );

   assign acc_sum = acc_q + (b_q[0] ? a_q : '0);
   assign b_shift = b_q >> 1;

`ifdef MUL_EARLY_TERM_EN
   assign last_cycle = (cnt_q == CW'(WIDTH - 1)) || (b_shift == '0);
`else
   assign last_cycle = (cnt_q == CW'(WIDTH - 1));
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               a_d     = {{WIDTH{1'b0}}, a_mag};
               b_d     = b_mag;
               sign_d  = signed_i & (multiplicand_i[WIDTH-1] ^ multiplier_i[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_sum;
            a_d   = a_q << 1;
            b_d   = b_shift;
            cnt_d = cnt_q + CW'(1);
            if (last_cycle) begin
               res_d   = res_fix;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mul_clk_i or posedge mul_reset_i) begin
      if (mul_reset_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         res_q   <= res_d;
      end
   end

   // Held low for the whole reset pulse, not just until the first edge.
   assign in_ready_o   = (state_q == IDLE) & ~mul_reset_i;
   assign out_valid_o  = (state_q == DONE);
   assign mul_result_o = res_q;

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Directed bench for param_seq_multiplier: one WIDTH=5 and one WIDTH=8
// instance share clock, reset and operand buses; sel8 picks which one a
// scenario drives and observes.
module tb_param_seq_multiplier;

`ifdef MUL_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv5 = 1'b0, iv8 = 1'b0;
   logic [7:0]  opa = '0, opb = '0;
   logic        sgn = 1'b0, ordy = 1'b0;
   logic        sel8 = 1'b0;

   logic        ir5, ov5, ir8, ov8;
   logic [9:0]  res5;
   logic [15:0] res8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   param_seq_multiplier #(.WIDTH(5)) dut5 (
      .mul_clk_i      (clk),
      .mul_reset_i    (rst),
      .in_valid_i     (iv5),
      .in_ready_o     (ir5),
      .multiplicand_i (opa[4:0]),
      .multiplier_i   (opb[4:0]),
      .signed_i       (sgn),
      .out_valid_o    (ov5),
      .out_ready_i    (ordy),
      .mul_result_o   (res5)
   );

   param_seq_multiplier #(.WIDTH(8)) dut8 (
      .mul_clk_i      (clk),
      .mul_reset_i    (rst),
      .in_valid_i     (iv8),
      .in_ready_o     (ir8),
      .multiplicand_i (opa),
      .multiplier_i   (opb),
      .signed_i       (sgn),
      .out_valid_o    (ov8),
      .out_ready_i    (ordy),
      .mul_result_o   (res8)
   );

   wire        ir_m  = sel8 ? ir8 : ir5;
   wire        ov_m  = sel8 ? ov8 : ov5;
   wire [15:0] res_m = sel8 ? res8 : {6'b0, res5};

   task automatic do_accept(input bit w8, input logic [7:0] a, input logic [7:0] b, input bit s);
      sel8 = w8;
      n_vec++;
      if (ir_m !== 1'b1) begin
         n_err++;
         $display("FAIL accept_ready: in_ready_o=%b required 1", ir_m);
      end
      opa = a; opb = b; sgn = s;
      iv5 = !w8; iv8 = w8;
      @(posedge clk); #1;
      iv5 = 1'b0; iv8 = 1'b0;
      // Operands changing during CALC must not disturb the result.
      opa = ~a; opb = ~b; sgn = !s;
   endtask

   task automatic wait_result(input int lat_full, input int lat_et, input logic [15:0] exp, input string nm);
      int cyc;
      int lat;
      cyc = 0;
      lat = ET ? lat_et : lat_full;
      while (ov_m !== 1'b1 && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_vec++;
      if (cyc != lat) begin
         n_err++;
         $display("FAIL %s_latency: got %0d cycles required %0d", nm, cyc, lat);
      end
      n_vec++;
      if (res_m !== exp) begin
         n_err++;
         $display("FAIL %s_result: got %h required %h", nm, res_m, exp);
      end
      n_vec++;
      if (ir_m !== 1'b0) begin
         n_err++;
         $display("FAIL %s_busy: in_ready_o=%b required 0", nm, ir_m);
      end
   endtask

   task automatic release_result(input logic [15:0] exp, input string nm);
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      n_vec++;
      if (ov_m !== 1'b0 || ir_m !== 1'b1 || res_m !== exp) begin
         n_err++;
         $display("FAIL %s_release: valid=%b ready=%b result=%h required 0 1 %h",
                  nm, ov_m, ir_m, res_m, exp);
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_vec++;
      if (ov5 !== 1'b0 || res5 !== 10'd0 || ir5 !== 1'b0 ||
          ov8 !== 1'b0 || res8 !== 16'd0 || ir8 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: ov5=%b res5=%h ir5=%b ov8=%b res8=%h ir8=%b required all 0",
                  ov5, res5, ir5, ov8, res8, ir8);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if (ir5 !== 1'b1 || ir8 !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: ir5=%b ir8=%b required 1 1", ir5, ir8);
      end
   endtask

   task automatic test_unsigned5();
      // out_ready held high: result is consumed the cycle after it appears.
      ordy = 1'b1;
      do_accept(1'b0, 8'd31, 8'd31, 1'b0);
      wait_result(5, 5, 16'h03C1, "u5_31x31");
      @(posedge clk); #1;
      ordy = 1'b0;
      n_vec++;
      if (ov_m !== 1'b0 || ir_m !== 1'b1 || res_m !== 16'h03C1) begin
         n_err++;
         $display("FAIL u5_autoconsume: valid=%b ready=%b result=%h required 0 1 03c1",
                  ov_m, ir_m, res_m);
      end
      do_accept(1'b0, 8'h15, 8'h0A, 1'b0);
      wait_result(5, 4, 16'd210, "u5_21x10");
      release_result(16'd210, "u5_21x10");
   endtask

   task automatic test_signed5();
      do_accept(1'b0, 8'h15, 8'h0A, 1'b1);
      wait_result(5, 4, 16'h0392, "s5_m11x10");
      release_result(16'h0392, "s5_m11x10");
   endtask

   task automatic test_signed8();
      do_accept(1'b1, 8'h80, 8'h80, 1'b1);
      wait_result(8, 8, 16'h4000, "s8_m128xm128");
      release_result(16'h4000, "s8_m128xm128");
      do_accept(1'b1, 8'h80, 8'h7F, 1'b1);
      wait_result(8, 7, 16'hC080, "s8_m128x127");
      release_result(16'hC080, "s8_m128x127");
      do_accept(1'b1, 8'h00, 8'hFB, 1'b1);
      wait_result(8, 3, 16'h0000, "s8_0xm5");
      release_result(16'h0000, "s8_0xm5");
      do_accept(1'b1, 8'hFF, 8'hFF, 1'b0);
      wait_result(8, 8, 16'hFE01, "u8_255x255");
      release_result(16'hFE01, "u8_255x255");
   endtask

   task automatic test_backpressure();
      do_accept(1'b0, 8'd7, 8'd3, 1'b0);
      wait_result(5, 2, 16'd21, "bp");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (ov_m !== 1'b1 || res_m !== 16'd21 || ir_m !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold_%0d: valid=%b result=%h ready=%b required 1 0015 0",
                     i, ov_m, res_m, ir_m);
         end
      end
      release_result(16'd21, "bp");
   endtask

   task automatic test_back_to_back();
      int k;
      ordy = 1'b1;
      do_accept(1'b0, 8'd5, 8'd6, 1'b0);
      wait_result(5, 3, 16'd30, "b2b_first");
      k = 0;
      while (ir_m !== 1'b1 && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      n_vec++;
      if (k != 1) begin
         n_err++;
         $display("FAIL b2b_gap: got %0d cycles to ready required 1", k);
      end
      do_accept(1'b0, 8'd2, 8'd3, 1'b0);
      wait_result(5, 2, 16'd6, "b2b_second");
      @(posedge clk); #1;
      ordy = 1'b0;
      n_vec++;
      if (ir_m !== 1'b1 || res_m !== 16'd6) begin
         n_err++;
         $display("FAIL b2b_end: ready=%b result=%h required 1 0006", ir_m, res_m);
      end
   endtask

   task automatic test_reset_mid_calc();
      do_accept(1'b0, 8'd9, 8'd13, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_vec++;
      if (ov5 !== 1'b0 || res5 !== 10'd0 || ir5 !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_state: valid=%b result=%h ready=%b required 0 000 0",
                  ov5, res5, ir5);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_vec++;
      if (ov5 !== 1'b0 || ir5 !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_hold: valid=%b ready=%b required 0 0", ov5, ir5);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if (ir5 !== 1'b1 || ov5 !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_release: ready=%b valid=%b required 1 0", ir5, ov5);
      end
      do_accept(1'b0, 8'd3, 8'd4, 1'b0);
      wait_result(5, 3, 16'd12, "after_reset_3x4");
      release_result(16'd12, "after_reset_3x4");
   endtask

   task automatic test_early_term();
      do_accept(1'b0, 8'd7, 8'd0, 1'b1);
      wait_result(5, 1, 16'd0, "et_7x0");
      release_result(16'd0, "et_7x0");
      do_accept(1'b0, 8'd7, 8'd1, 1'b1);
      wait_result(5, 1, 16'd7, "et_7x1");
      release_result(16'd7, "et_7x1");
      do_accept(1'b0, 8'd7, 8'd4, 1'b1);
      wait_result(5, 3, 16'd28, "et_7x4");
      release_result(16'd28, "et_7x4");
      do_accept(1'b0, 8'd7, 8'h10, 1'b1);
      wait_result(5, 5, 16'h0390, "et_7xm16");
      release_result(16'h0390, "et_7xm16");
   endtask

   initial begin
      test_reset();
      test_unsigned5();
      test_signed5();
      test_signed8();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_calc();
      test_early_term();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
